// File: rtl/display_scan_if.sv
// Display scan bus: load handshake from the producer plus the scan outputs that
// go to the shared 7-segment decoder and the digit anode drivers.
//   load_valid  producer -> block  new display value offered
//   load_value  producer -> block  four hex digits, [3:0] is digit 0
//   load_ready  block -> producer  block can accept a value
//   blank_lz    producer -> block  leading-zero blanking enable
//   nibble_out  block -> decoder   digit code for the registered decoder
//   anode_n     block -> drivers   active-low digit enables, bit i = digit i
//   digit_idx   block -> observer  current slot index
//   frame_start block -> observer  one-cycle pulse entering digit 0 guard
interface display_scan_if;

    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic        blank_lz;
    logic [3:0]  nibble_out;
    logic [3:0]  anode_n;
    logic [1:0]  digit_idx;
    logic        frame_start;

    // Producer / observer side
    modport master (
        output load_valid,
        output load_value,
        output blank_lz,
        input  load_ready,
        input  nibble_out,
        input  anode_n,
        input  digit_idx,
        input  frame_start
    );

    // Scan controller side
    modport slave (
        input  load_valid,
        input  load_value,
        input  blank_lz,
        output load_ready,
        output nibble_out,
        output anode_n,
        output digit_idx,
        output frame_start
    );

endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner. Each digit slot is a GUARD dead-time
// (anodes off while the registered decoder settles) followed by a SCAN period
// with one anode enabled. New values are double-buffered and only applied at a
// frame boundary so a frame never mixes two values.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    display_scan_if.slave (handshake, blanking enable, scan outputs)
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    display_scan_if.slave    bus
);

    localparam int unsigned SCAN_W  = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int unsigned GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_GUARD = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [SCAN_W-1:0]   scan_cnt_q,    scan_cnt_d;
    logic [GUARD_W-1:0]  guard_cnt_q,   guard_cnt_d;
    logic [15:0]         active_q,      active_d;
    logic [15:0]         shadow_q,      shadow_d;
    logic                pending_q,     pending_d;
    logic [1:0]          idx_q,         idx_d;
    logic [3:0]          nibble_q,      nibble_d;
    logic [3:0]          anode_q,       anode_d;
    logic                frame_start_q, frame_start_d;
    logic                load_ready_q,  load_ready_d;
    logic                accept_c;

    // Digit i>0 is a leading zero when digits i..3 of the value are all zero.
    function automatic logic lz_blanked(input logic [15:0] v, input logic [1:0] i);
        logic r;
        case (i)
            2'd1:    r = (v[15:4]  == 12'h000);
            2'd2:    r = (v[15:8]  == 8'h00);
            2'd3:    r = (v[15:12] == 4'h0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign accept_c = bus.load_valid & load_ready_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            scan_cnt_q    <= '0;
            guard_cnt_q   <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            idx_q         <= '0;
            nibble_q      <= '0;
            anode_q       <= 4'hF;
            frame_start_q <= 1'b0;
            load_ready_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            scan_cnt_q    <= scan_cnt_d;
            guard_cnt_q   <= guard_cnt_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            idx_q         <= idx_d;
            nibble_q      <= nibble_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
            load_ready_q  <= load_ready_d;
        end
    end

    // Next-state, buffering and registered-output logic
    always_comb begin
        state_d       = state_q;
        scan_cnt_d    = scan_cnt_q;
        guard_cnt_d   = guard_cnt_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        idx_d         = idx_q;
        nibble_d      = nibble_q;
        anode_d       = 4'hF;
        frame_start_d = 1'b0;
        load_ready_d  = load_ready_q;

        case (state_q)
            ST_BLANK: begin
                if (accept_c) begin
                    active_d    = bus.load_value;
                    idx_d       = 2'd0;
                    guard_cnt_d = '0;
                    state_d     = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    scan_cnt_d = '0;
                    state_d    = ST_SCAN;
                end else begin
                    guard_cnt_d = guard_cnt_q + GUARD_W'(1);
                end
            end
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    guard_cnt_d = '0;
                    idx_d       = idx_q + 2'd1;
                    state_d     = ST_GUARD;
                    // Frame boundary: swap in the buffered value
                    if (idx_q == 2'd3 && pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase

        // Loads while scanning are buffered; accept only happens with pending clear,
        // so this never collides with the boundary swap above.
        if (accept_c && state_q != ST_BLANK) begin
            shadow_d  = bus.load_value;
            pending_d = 1'b1;
        end

        // Nibble changes only on guard entry, so the decoder settles with anodes off.
        if (state_d == ST_GUARD && state_q != ST_GUARD) begin
            nibble_d      = 4'(active_d >> {idx_d, 2'b00});
            frame_start_d = (idx_d == 2'd0);
        end

        if (state_d == ST_SCAN && !(bus.blank_lz && lz_blanked(active_d, idx_d))) begin
            anode_d = ~(4'b0001 << idx_d);
        end

        load_ready_d = ~pending_d;
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.nibble_out  = nibble_q;
    assign bus.anode_n     = anode_q;
    assign bus.digit_idx   = idx_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized self-checking bench for display_scan_controller with a
// frame-position reference model (slot = t/6, guard when t%6 < 2).
module tb_display_scan_controller;

    localparam int unsigned RD    = 4;
    localparam int unsigned GC    = 2;
    localparam int          SLOT  = 6;
    localparam int          FRAME = 24;

    logic clk;
    logic rst_n;

    display_scan_if bus ();

    display_scan_controller #(
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int en_cnt [4];

    // Reference model: position within the frame plus the value buffers
    bit          m_run;
    int          m_t;
    logic [15:0] m_act;
    logic [15:0] m_sh;
    bit          m_pend;
    bit          m_blz;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_t    = 0;
        m_act  = '0;
        m_sh   = '0;
        m_pend = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [15:0] val, input bit blz);
        bit acc;
        acc   = v && !m_pend;
        m_blz = blz;
        if (!m_run) begin
            if (acc) begin
                m_run = 1'b1;
                m_t   = 0;
                m_act = val;
            end
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0 && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_sh   = val;
                m_pend = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] exp_anode();
        int slot;
        logic [3:0] a;
        logic [15:0] upper;
        a = 4'hF;
        if (m_run) begin
            slot  = m_t / SLOT;
            upper = m_act >> (4 * slot);
            if ((m_t % SLOT) >= int'(GC) && !(m_blz && slot > 0 && upper == 16'h0))
                a[slot] = 1'b0;
        end
        return a;
    endfunction

    function automatic logic [3:0] exp_nibble();
        logic [15:0] sh;
        sh = m_run ? (m_act >> (4 * (m_t / SLOT))) : 16'h0;
        return sh[3:0];
    endfunction

    task automatic check_outputs();
        logic [1:0] idx;
        idx = m_run ? 2'(m_t / SLOT) : 2'd0;
        check("anode_n",     16'(bus.anode_n),     16'(exp_anode()));
        check("nibble_out",  16'(bus.nibble_out),  16'(exp_nibble()));
        check("digit_idx",   16'(bus.digit_idx),   16'(idx));
        check("load_ready",  16'(bus.load_ready),  16'(!m_pend));
        check("frame_start", 16'(bus.frame_start), 16'(m_run && m_t == 0));
    endtask

    // One clock: model follows the inputs seen at the edge, outputs checked at negedge
    task automatic cycle();
        @(posedge clk);
        model_edge(bus.load_valid, bus.load_value, bus.blank_lz);
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 4; i++)
            if (bus.anode_n[i] == 1'b0) en_cnt[i]++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called at a negedge; reset takes effect without a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_async_anode", 16'(bus.anode_n),    16'hF);
        check("rst_async_ready", 16'(bus.load_ready), 16'h1);
        check("rst_async_fs",    16'(bus.frame_start), 16'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic wait_pos(input int target, input bit need_free, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (m_run && m_t == target && (!need_free || !m_pend)) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        if (!ok && m_run && m_t == target && (!need_free || !m_pend)) ok = 1'b1;
    endtask

    task automatic load(input logic [15:0] val);
        bus.load_valid = 1'b1;
        bus.load_value = val;
        cycle();
        bus.load_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [15:0] v;

        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        bus.blank_lz   = 1'b0;
        model_reset();
        m_blz = 1'b0;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Idle after reset: blank, ready, no frame pulses
        run(50);

        // 0x1234 from BLANK
        load(16'h1234);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            if (m_t == 2) begin
                check("d0_anode",  16'(bus.anode_n),    16'hE);
                check("d0_nibble", 16'(bus.nibble_out), 16'h4);
            end
            if (m_t == 14) begin
                check("d2_anode",  16'(bus.anode_n),    16'hB);
                check("d2_nibble", 16'(bus.nibble_out), 16'h2);
            end
        end

        // Leading-zero blanking of 0x0050
        do_reset();
        bus.blank_lz = 1'b1;
        for (int i = 0; i < 4; i++) en_cnt[i] = 0;
        load(16'h0050);
        run(FRAME - 1);
        check("lz50_d3", 16'(en_cnt[3]), 16'd0);
        check("lz50_d2", 16'(en_cnt[2]), 16'd0);
        check("lz50_d1", 16'(en_cnt[1]), 16'(RD));
        check("lz50_d0", 16'(en_cnt[0]), 16'(RD));

        // All-zero value: only digit 0 ever lit
        do_reset();
        for (int i = 0; i < 4; i++) en_cnt[i] = 0;
        load(16'h0000);
        run(2 * FRAME - 1);
        check("lz0_d3", 16'(en_cnt[3]), 16'd0);
        check("lz0_d2", 16'(en_cnt[2]), 16'd0);
        check("lz0_d1", 16'(en_cnt[1]), 16'd0);
        check("lz0_d0", 16'(en_cnt[0]), 16'(2 * RD));
        bus.blank_lz = 1'b0;

        // Mid-frame load, then a held offer that must wait for the boundary
        wait_pos(8, 1'b1, 3 * FRAME, ok);
        check("wait_mid", 16'(ok), 16'h1);
        load(16'hBEEF);
        bus.load_valid = 1'b1;
        bus.load_value = 16'hAAAA;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            if (m_pend && m_sh == 16'hAAAA) begin
                ok = 1'b1;
                break;
            end
        end
        check("held_accept", 16'(ok), 16'h1);
        bus.load_valid = 1'b0;
        run(2 * FRAME);

        // Load on the boundary edge lands one frame later
        wait_pos(FRAME - 1, 1'b1, 3 * FRAME, ok);
        check("wait_bnd", 16'(ok), 16'h1);
        load(16'h5678);
        check("bnd_old_nibble", 16'(bus.nibble_out), 16'hA);
        run(FRAME);
        check("bnd_new_nibble", 16'(bus.nibble_out), 16'h8);
        run(FRAME);

        // Reset mid-SCAN of digit 2 with a value pending
        wait_pos(3, 1'b1, 3 * FRAME, ok);
        check("wait_pend", 16'(ok), 16'h1);
        load(16'h9999);
        wait_pos(15, 1'b0, 2 * FRAME, ok);
        check("wait_d2", 16'(ok), 16'h1);
        do_reset();
        run(30);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       v &= 16'h000F;
                1:       v &= 16'h00FF;
                2:       v &= 16'h0FFF;
                default: ;
            endcase
            bus.load_value = v;
            bus.load_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, meaning SCAN cycles per digit slot; legal range is 2 or more.
REQ-002 Parameter GUARD_CYCLES, default 2, meaning anodes-off dead-time cycles before each slot; legal range is 1 or more, which also covers the 1-cycle registered decoder latency.
REQ-003 The digit count SHALL be fixed at 4.
REQ-004 The clock SHALL be `clk`, input, 1 bit, sole clock, with all state updated on its rising edge.
REQ-005 The reset SHALL be `rst_n`, input, 1 bit, asynchronous and active-low.
REQ-006 `load_valid` SHALL be an input, 1 bit: the producer offers a new display value.
REQ-007 `load_value` SHALL be an input, 16 bits: four hex digits, with [3:0] as digit 0 (least significant).
REQ-008 `load_ready` SHALL be an output, 1 bit: the block can accept a value.
REQ-009 `blank_lz` SHALL be an input, 1 bit: leading-zero blanking enable.
REQ-010 `nibble_out` SHALL be an output, 4 bits: the digit code driven to the shared, registered binary-to-7-segment decoder.
REQ-011 `anode_n` SHALL be an output, 4 bits: active-low digit enables, where bit i enables digit i.
REQ-012 `digit_idx` SHALL be an output, 2 bits: the current slot index.
REQ-013 `frame_start` SHALL be an output, 1 bit: a one-cycle pulse on entry to the GUARD state of digit 0.

Function
REQ-014 The FSM SHALL have three states: BLANK, GUARD and SCAN.
REQ-015 BLANK SHALL be the post-reset state, with anode_n=4'b1111 and load_ready=1.
REQ-016 Handshake: a transfer SHALL occur on any rising edge where load_valid and load_ready are both 1; the block SHALL ignore load_valid while load_ready=0.
REQ-017 Transfer in BLANK, on the same edge: active value <= load_value, digit_idx <= 0, nibble_out <= load_value[3:0], state <= GUARD, frame_start=1 in the next cycle.
REQ-018 GUARD SHALL hold anode_n=4'b1111 for exactly GUARD_CYCLES cycles, then go to SCAN.
REQ-019 SCAN SHALL last exactly REFRESH_DIV cycles, with anode_n[digit_idx]=0 and all other bits 1, except when the digit is blanked (see REQ-024).
REQ-020 At the end of SCAN, the FSM SHALL go to GUARD, with digit_idx <= digit_idx+1 mod 4 and nibble_out <= the new digit's nibble, both updated on the same edge.
REQ-021 Transfer outside BLANK: the value SHALL go to a shadow register, set pending=1, and drive load_ready=0 from the next cycle.
REQ-022 Frame boundary (SCAN end with digit_idx=3): if pending=1, active <= shadow, pending <= 0, and nibble_out SHALL come from the new active value; load_ready SHALL return to 1 in the following cycle.
REQ-023 A transfer on the boundary edge itself SHALL land in the shadow register and apply at the next boundary; no value SHALL ever change mid-frame.
REQ-024 Leading-zero blanking: with blank_lz=1, digit i>0 SHALL keep its anode off during its SCAN if active digits i..3 are all zero; digit 0 SHALL never be blanked; nibble_out and all timing SHALL be unchanged by blanking.
REQ-025 blank_lz SHALL be evaluated every cycle, so a change takes effect within the current slot.
REQ-026 The prescaler and guard counters SHALL be cleared on every state entry; wrap SHALL be exact, with no slot stretched or shortened.
REQ-027 At most one anode_n bit SHALL be 0 in any cycle, and anode_n SHALL be 4'b1111 on every cycle in which nibble_out changed within the previous GUARD_CYCLES cycles.
REQ-028 The block SHALL never return to BLANK except through reset.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately, without waiting for clk, force: state=BLANK, anode_n=4'b1111, nibble_out=0, digit_idx=0, frame_start=0, load_ready=1, active=0, shadow=0, pending=0, all counters 0.
REQ-030 Reset asserted mid-SCAN or mid-GUARD SHALL discard both the active and the pending value.
REQ-031 Deassertion SHALL be synchronised externally; the first rising edge after release is a normal BLANK cycle.

Verification (REFRESH_DIV=4, GUARD_CYCLES=2; slot = 6 cycles, frame = 24 cycles)
REQ-032 Reset with no load for 50 cycles -> anode_n=4'b1111, load_ready=1 and frame_start=0 throughout.
REQ-033 Load 0x1234 from BLANK -> frame_start pulse; 2 cycles at 1111; 4 cycles at 1110 with nibble_out=4; 2 cycles at 1111; 4 cycles at 1101 with nibble=3; then 1011/2 and 0111/1; repeating every 24 cycles.
REQ-034 blank_lz=1 and load 0x0050 -> anodes for digits 3 and 2 stay off; digit 1 shows 5 and digit 0 shows 0; with load 0x0000, only digit 0 is ever enabled.
REQ-035 Mid-frame load of 0xBEEF, then load_valid held with 0xAAAA -> load_ready=0 until the boundary; the next frame shows F,E,E,B; 0xAAAA is accepted only after load_ready returns to 1.
REQ-036 Load issued on the exact boundary edge -> the current frame completes with the old value and the new value appears one frame later.
REQ-037 rst_n pulsed low mid-SCAN of digit 2 -> anode_n=4'b1111 and load_ready=1 asynchronously; the pending value is lost and the display stays blank until a new load.
